// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared AES decryption constants, the sequencer state type and GF(2^8) helpers.
// Optional feature macro used by this slice: INVMIX_BYPASS_EN.
package aes_dec_pkg;

  localparam int AES_NUM_COLS = 4;
  localparam int AES_COL_W    = 32;
  localparam int AES_STATE_W  = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Upstream/downstream valid-ready bundle of the InvMixColumns sequencer.
// in_bypass exists only when INVMIX_BYPASS_EN is defined.
interface inv_mix_columns_seq_if;
  // A transfer happens on a rising edge where valid and ready are both 1;
  // the sender keeps valid and data stable until that edge.
  logic                            in_valid;
  logic                            in_ready;
  logic [aes_dec_pkg::AES_STATE_W-1:0] in_state;
`ifdef INVMIX_BYPASS_EN
  logic                            in_bypass;
`endif
  logic                            out_valid;
  logic                            out_ready;
  logic [aes_dec_pkg::AES_STATE_W-1:0] out_state;

  modport master (
    output in_valid, in_state,
`ifdef INVMIX_BYPASS_EN
    output in_bypass,
`endif
    output out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state,
`ifdef INVMIX_BYPASS_EN
    input  in_bypass,
`endif
    input  out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/inv_mix_columns_seq_helper.sv
// InvMixColumns on one 32-bit column; row 0 is the most significant byte.
module MixColumnHelper
  import aes_dec_pkg::*;
(
  input  logic [AES_COL_W-1:0] rc,
  output logic [AES_COL_W-1:0] mcl
);

  logic [7:0] a [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]  = rc[AES_COL_W-1-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
  end

  assign mcl = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial InvMixColumns: one shared helper, four RUN cycles per state.
// INVMIX_BYPASS_EN adds in_bypass for the final round (state copied unchanged).
module inv_mix_columns_seq
  import aes_dec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  inv_mix_columns_seq_if.slave  bus,
  output state_t                fsm_state
);

  localparam logic [1:0] LAST_COL = 2'(AES_NUM_COLS - 1);

  state_t state_q, state_d;
  logic [AES_NUM_COLS-1:0][AES_COL_W-1:0] src_q, res_q;
  logic [1:0]           col_q;
  logic [1:0]           slot;
  logic [AES_COL_W-1:0] rc, mcl;
  logic                 accept, bypass, in_ready, out_valid;

`ifdef INVMIX_BYPASS_EN
  assign bypass = bus.in_bypass;
`else
  assign bypass = 1'b0;
`endif

  // Column 0 sits in the top word, i.e. packed element 3.
  assign slot = LAST_COL - col_q;
  assign rc   = src_q[slot];

  MixColumnHelper u_helper (
    .rc  (rc),
    .mcl (mcl)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = bypass ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (col_q == LAST_COL) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      res_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q <= bus.in_state;
        col_q <= '0;
        if (bypass) res_q <= bus.in_state;
      end else if (state_q == ST_RUN) begin
        res_q[slot] <= mcl;
        col_q       <= col_q + 2'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_state = res_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq using hand-computed InvMixColumns vectors.
module tb_inv_mix_columns_seq;
  import aes_dec_pkg::*;

  localparam logic [127:0] FIPS_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] ONES     = {16{8'h01}};
  localparam logic [127:0] ALT_IN   = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] ALT_OUT  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t fsm_state;
  int     n_vec  = 0;
  int     n_miss = 0;
  int     cyc    = 0;

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one state, wait for the result, hold it for `hold` cycles, then drain.
  task automatic run_vec(input string tag, input logic [127:0] v, input logic [127:0] exp,
                         input logic byp, input int exp_lat, input int hold);
    int lat;
    bus.in_valid = 1'b1;
    bus.in_state = v;
`ifdef INVMIX_BYPASS_EN
    bus.in_bypass = byp;
`endif
    check_int({tag, "_in_ready"}, int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_state = ~v;
`ifdef INVMIX_BYPASS_EN
    bus.in_bypass = 1'b0;
`endif
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_int({tag, "_latency"}, lat, exp_lat);
    check_word({tag, "_out_state"}, bus.out_state, exp);
    check_int({tag, "_busy_in_ready"}, int'(bus.in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_int({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      check_word({tag, "_hold_state"}, bus.out_state, exp);
      check_int({tag, "_hold_in_ready"}, int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_int({tag, "_drain_in_ready"}, int'(bus.in_ready), 1);
    check_int({tag, "_drain_valid"}, int'(bus.out_valid), 0);
    if (byp) begin end
  endtask

  initial begin
    int a1, a2, lat;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b0;
`ifdef INVMIX_BYPASS_EN
    bus.in_bypass = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    check_int("reset_in_ready", int'(bus.in_ready), 1);
    check_int("reset_out_valid", int'(bus.out_valid), 0);
    check_word("reset_out_state", bus.out_state, '0);
    check_int("reset_fsm", int'(fsm_state), int'(ST_IDLE));

    // FIPS-197 vector with 10 cycles of back-pressure.
    run_vec("fips", FIPS_IN, FIPS_OUT, 1'b0, 4, 10);
    run_vec("ones", ONES, ONES, 1'b0, 4, 0);
    run_vec("zero", '0, '0, 1'b0, 4, 0);

    // Reset in the second RUN cycle discards the state.
    bus.in_valid = 1'b1;
    bus.in_state = FIPS_IN;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_int("midrst_fsm", int'(fsm_state), int'(ST_IDLE));
    check_int("midrst_in_ready", int'(bus.in_ready), 1);
    check_word("midrst_out_state", bus.out_state, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_int("midrst_no_valid", int'(bus.out_valid), 0);
    end
    run_vec("fips_after_rst", FIPS_IN, FIPS_OUT, 1'b0, 4, 0);

    // Reset together with in_valid accepts nothing.
    bus.in_valid = 1'b1;
    bus.in_state = ALT_IN;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_int("rst_valid_fsm", int'(fsm_state), int'(ST_IDLE));

    // Back-to-back with out_ready tied high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = FIPS_IN;
    check_int("b2b_first_ready", int'(bus.in_ready), 1);
    a1 = cyc;
    tick();
    bus.in_state = ALT_IN;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_word("b2b_first_out", bus.out_state, FIPS_OUT);
    tick();
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      tick();
      lat++;
    end
    a2 = cyc;
    check_int("b2b_spacing", a2 - a1, 6);
    tick();
    bus.in_valid = 1'b0;
    bus.in_state = 128'h0123456789abcdef_fedcba9876543210;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_int("b2b_second_latency", lat, 4);
    check_word("b2b_second_out", bus.out_state, ALT_OUT);
    tick();
    bus.out_ready = 1'b0;
    check_int("b2b_idle", int'(fsm_state), int'(ST_IDLE));

`ifdef INVMIX_BYPASS_EN
    run_vec("bypass", FIPS_IN, FIPS_IN, 1'b1, 0, 0);
    run_vec("no_bypass", FIPS_IN, FIPS_OUT, 1'b0, 4, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
